// File: rtl/uart_wb_host_if.sv
// Command/response stream and UART register-bus signals of uart_wb_host.
// The host side (the bridge itself) uses the master modport. The peer side,
// which is the sequencer plus the UART, uses the slave modport.
interface uart_wb_host_if;
    // Command stream
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    // Response stream
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    // UART strobed register bus
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_clk;
    logic       wb_ack;

    modport master (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata,
        input  rsp_ready, wb_data_in, wb_ack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output wb_addr, wb_data_out, wb_we, wb_stb, wb_clk
    );

    modport slave (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata,
        output rsp_ready, wb_data_in, wb_ack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wb_addr, wb_data_out, wb_we, wb_stb, wb_clk
    );
endinterface

// File: rtl/uart_wb_host.sv
// Bus initiator for the UART register port. Each accepted command becomes a
// single strobed transfer: the address, data and we signals are set up,
// wb_clk is raised, the bridge waits for ack to rise and then to fall, and
// finally one response carrying read data or a timeout flag is returned.
// All outputs are registered.
module uart_wb_host #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset,
    uart_wb_host_if.master bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // The counters are compared with >=, so they can never run past the limit.
    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [1:0]  wb_addr_q,   wb_addr_d;
    logic [7:0]  wb_data_q,   wb_data_d;
    logic        wb_we_q,     wb_we_d;
    logic        wb_stb_q,    wb_stb_d;
    logic        wb_clk_q,    wb_clk_d;

    // Transfer sequencing: the next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_we_d     = wb_we_q;
        wb_stb_d    = wb_stb_q;
        wb_clk_d    = wb_clk_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    wb_addr_d = bus.cmd_addr;
                    wb_data_d = bus.cmd_wdata;
                    wb_we_d   = bus.cmd_read;
                    wb_stb_d  = 1'b1;
                    wb_clk_d  = 1'b0;
                    cnt_d     = 16'd0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // A stale ack seen here is ignored. Only the ack sampled in
                // STROBE, after wb_clk has risen, counts.
                if (cnt_q >= SETUP_LAST) begin
                    wb_clk_d = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STROBE: begin
                if (bus.wb_ack) begin
                    rsp_rdata_d = wb_we_q ? bus.wb_data_in : 8'h00;
                    wb_clk_d    = 1'b0;
                    cnt_d       = 16'd0;
                    state_d     = ST_RELEASE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'h00;
                    wb_clk_d    = 1'b0;
                    cnt_d       = 16'd0;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                // After a strobe timeout, strobe is held for one more full
                // window. A late ack from the UART can then rise and fall
                // before the next transfer starts.
                if (!bus.wb_ack && !rsp_err_q) begin
                    wb_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    rsp_err_d   = 1'b1;
                    wb_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // cmd_ready is registered, so it rises on the cycle after the
        // response handshake.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers, with synchronous reset to the idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            wb_addr_q   <= 2'd0;
            wb_data_q   <= 8'h00;
            wb_we_q     <= 1'b1;
            wb_stb_q    <= 1'b0;
            wb_clk_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_we_q     <= wb_we_d;
            wb_stb_q    <= wb_stb_d;
            wb_clk_q    <= wb_clk_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data_out = wb_data_q;
    assign bus.wb_we       = wb_we_q;
    assign bus.wb_stb      = wb_stb_q;
    assign bus.wb_clk      = wb_clk_q;

endmodule

// File: doc/uart_wb_host.md
Name: uart_wb_host

Overview:
- Bus initiator for the UART's register port: converts a valid/ready command stream into single transfers on the UART's strobed bus (addr/data/we/stb/wb_clk, ack returned).
- Sits between a CPU-side or test sequencer and the UART block, on the same clk.
- Returns read data and a timeout error per transfer through a valid/ready response channel.

Parameters:
- SETUP_CYCLES, 2, clk cycles that addr/data/we/stb are held stable before wb_clk rises; 1..255.
- TIMEOUT_CYCLES, 1024, max clk cycles spent waiting for each ack edge; 16-bit counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_read  in  1  1 = read, 0 = write
- cmd_addr  in  2  0x0 TX data, 0x1 RX data, 0x2 frequency divider
- cmd_wdata  in  8  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  8  read data; 0x00 for writes and on timeout
- rsp_err  out  1  1 = transfer timed out
- wb_addr  out  2  bus address
- wb_data_out  out  8  write data to UART
- wb_data_in  in  8  read data from UART
- wb_we  out  1  0 = write, 1 = read (UART polarity)
- wb_stb  out  1  transfer strobe
- wb_clk  out  1  transfer phase strobe
- wb_ack  in  1  UART acknowledge

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1. rsp_valid=0, rsp_rdata=0, rsp_err=0, wb_stb=0, wb_clk=0, wb_we=1 (read, harmless idle), wb_addr=0, wb_data_out=0. State IDLE, counters 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, RELEASE, RESP.
- IDLE: cmd_ready=1. On accept:
  - latch wb_addr=cmd_addr, wb_data_out=cmd_wdata, wb_we=cmd_read.
  - wb_stb<=1, wb_clk stays 0, counter cleared.
  - go to SETUP.
- SETUP: count SETUP_CYCLES cycles, then wb_clk<=1, clear counter, go to STROBE.
- STROBE: wait for wb_ack=1.
  - On ack: capture rsp_rdata=wb_data_in if wb_we=1, else 0x00. Then wb_clk<=0, go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: rsp_err<=1, rsp_rdata<=0, wb_clk<=0, go to RELEASE.
- RELEASE: wait for wb_ack=0, then wb_stb<=0, rsp_valid<=1, go to RESP.
  - On timeout here: rsp_err<=1, wb_stb<=0, rsp_valid<=1, go to RESP.
- RESP: hold rsp_* stable until rsp_ready.
  - On handshake: rsp_valid<=0, rsp_err<=0, return to IDLE.
  - cmd_ready rises on the cycle after the handshake. Commands are never accepted while a response is pending (no overlap).
- Minimum latency, accept to rsp_valid, with immediate ack: SETUP_CYCLES + 3 cycles.
- wb_ack high in IDLE or SETUP (stale ack from a prior aborted transfer): ignored. STROBE still requires an ack sampled after wb_clk=1.
- cmd_valid is ignored outside IDLE, and cmd_* may change freely after accept.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Reset mid-transfer, in any state: all outputs return to reset values on the next edge. wb_stb/wb_clk drop immediately and any pending response is discarded.
- Timeout counter is 16 bits, saturating compare. It never wraps within a state.

Test Plan:
- Write: cmd write addr=0x0 data=0x55, UART model acks 2 cycles after wb_clk=1 and drops ack 1 cycle after wb_clk=0.
  - Required: wb_we=0, wb_addr=0, wb_data_out=0x55 stable from stb rise to stb fall.
  - Required: rsp_valid with rsp_err=0, rsp_rdata=0x00.
- Read: cmd read addr=0x1, model returns 0x41 with ack.
  - Required: wb_we=1, rsp_rdata=0x41, rsp_err=0.
  - Required: latency from accept to rsp_valid = SETUP_CYCLES+3+2 ack delay.
- Divider write: cmd write addr=0x2 data=0x4E, then read addr=0x1 back-to-back with rsp_ready held high.
  - Required: two distinct transfers, wb_stb low ≥1 cycle between them, cmd_ready low until the first response is consumed.
- Timeout: model never acks, TIMEOUT_CYCLES=16.
  - Required: wb_clk falls 16 cycles after rising, then RELEASE times out 16 cycles later.
  - Required: rsp_err=1, rsp_rdata=0, wb_stb=0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: rsp_rdata/rsp_err held stable, cmd_ready=0 throughout, and a cmd_valid pulse in that window is ignored.
- Reset mid-STROBE: assert reset while wb_clk=1.
  - Required: next edge gives wb_stb=0, wb_clk=0, rsp_valid=0, wb_we=1.
  - Required: a fresh write afterwards completes normally.
